// File: rtl/sensor_sample_sched.sv
// sensor_sample_sched: paced sensor sampling into a small FIFO streamed out over valid/ready with end-of-frame marking.
module sensor_sample_sched #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] sensor_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
  logic [LEN_W-1:0] len_q, len_d, smp_cnt_q, smp_cnt_d;
  logic overrun_q, overrun_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic empty, full, tick, last, push, pop;
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign tick = state_q == RUN && div_cnt_q == div_q;
  assign last = smp_cnt_q == len_q - LEN_W'(1);
  assign push = tick && !full;
  assign pop = m_valid && m_ready;
  assign m_valid = !empty;
  assign m_data = empty ? '0 : mem_q[rd_q[AW-1:0]][DATA_W-1:0];
  assign m_last = empty ? 1'b0 : mem_q[rd_q[AW-1:0]][DATA_W];
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign overrun = overrun_q;
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    len_d = len_q;
    div_cnt_d = div_cnt_q;
    smp_cnt_d = smp_cnt_q;
    overrun_d = overrun_q;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
    case (state_q)
      IDLE: if (start) begin
        div_d = sample_div;
        len_d = frame_len;
        overrun_d = 1'b0;
        div_cnt_d = '0;
        smp_cnt_d = '0;
        state_d = frame_len == '0 ? DONE : RUN;
      end
      RUN: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
          smp_cnt_d = smp_cnt_q + LEN_W'(1);
          overrun_d = overrun_q | full;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: if (rd_d == wr_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      wr_d = '0;
      rd_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q <= '0;
      len_q <= '0;
      div_cnt_q <= '0;
      smp_cnt_q <= '0;
      overrun_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      len_q <= len_d;
      div_cnt_q <= div_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      overrun_q <= overrun_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // Storage needs no reset: entries are only visible behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {last, sensor_data};
  end
endmodule
